// File: rtl/udma_evt_arbiter.sv
// Round-robin concentrator that merges per-source event pulses onto the single uDMA event channel.
// Each source keeps a saturating pending count; sticky overflow flags record pulses that were lost.
module udma_evt_arbiter #(
    parameter int unsigned N_SRC    = 8,
    parameter int unsigned CNT_W    = 2,
    parameter logic [7:0]  EVT_BASE = 8'h00
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic [N_SRC-1:0] src_evt_i,
    output logic             event_valid_o,
    output logic [7:0]       event_data_o,
    input  logic             event_ready_i,
    output logic [N_SRC-1:0] ovf_o,
    input  logic [N_SRC-1:0] ovf_clr_i,
    output logic             busy_o
);

    localparam int unsigned     PtrW   = $clog2(N_SRC);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [PtrW-1:0]  PtrRst = PtrW'(N_SRC - 1);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e           state_q;
    logic [7:0]       data_q;
    logic [PtrW-1:0]  ptr_q;
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [CNT_W-1:0] cnt_d [N_SRC];
    logic [N_SRC-1:0] ovf_q, ovf_d;
    logic [N_SRC-1:0] req, dec;
    logic [PtrW-1:0]  sel;
    logic             sel_found;
    logic             accept;
    logic             load;
    int unsigned      idx;

    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    // Search starts just after the last winner, so the previous winner is considered last.
    always_comb begin
        sel       = ptr_q;
        sel_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (32'(ptr_q) + k) % N_SRC;
            if (!sel_found && req[PtrW'(idx)]) begin
                sel       = PtrW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign accept = event_valid_o & event_ready_i;
    assign load   = enable_i & sel_found & ((state_q == StIdle) | accept);

    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            dec[i]   = load && (sel == PtrW'(i));
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (src_evt_i[i] && !dec[i]) begin
                if (cnt_q[i] != CntMax) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!src_evt_i[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            // A lost pulse outranks a same-cycle clear.
            if (src_evt_i[i] && !dec[i] && (cnt_q[i] == CntMax)) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr_i[i]) begin
                ovf_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            ptr_q   <= PtrRst;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q <= StOffer;
                    end
                end
                StOffer: begin
                    if (accept && !load) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Loads only happen when no offer is pending or it is being accepted: no retraction.
            if (load) begin
                data_q <= EVT_BASE + 8'(sel);
                ptr_q  <= sel;
            end
        end
    end

    assign event_valid_o = (state_q == StOffer);
    assign event_data_o  = data_q;
    assign ovf_o         = ovf_q;
    assign busy_o        = event_valid_o | (|req);

endmodule

// File: tb/tb_udma_evt_arbiter.sv
// Scenario and randomized checks of udma_evt_arbiter against a transaction-level reference model.
module tb_udma_evt_arbiter;

    localparam int         N    = 8;
    localparam int         CW   = 2;
    localparam int         MAX  = 3;
    localparam logic [7:0] BASE = 8'h10;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         enable_i = 1'b0;
    logic [N-1:0] src_evt_i = '0;
    logic         event_valid_o;
    logic [7:0]   event_data_o;
    logic         event_ready_i = 1'b0;
    logic [N-1:0] ovf_o;
    logic [N-1:0] ovf_clr_i = '0;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_cnt [N];
    logic [N-1:0] m_ovf;
    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;

    udma_evt_arbiter #(.N_SRC(N), .CNT_W(CW), .EVT_BASE(BASE)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .src_evt_i    (src_evt_i),
        .event_valid_o(event_valid_o),
        .event_data_o (event_data_o),
        .event_ready_i(event_ready_i),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_busy();
        bit b = m_valid;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ovf   = '0;
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
    task automatic tick();
        int         n_cnt [N];
        logic [N-1:0] n_ovf;
        int         n_ptr;
        bit         n_valid;
        logic [7:0] n_data;
        int         sel;
        bit         ld;
        int         idx;
        sel = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (sel < 0 && m_cnt[idx] != 0) sel = idx;
        end
        ld      = enable_i && (sel >= 0) && (!m_valid || event_ready_i);
        n_cnt   = m_cnt;
        n_ovf   = m_ovf;
        n_ptr   = m_ptr;
        n_valid = m_valid;
        n_data  = m_data;
        for (int i = 0; i < N; i++) begin
            int inc = int'(src_evt_i[i]);
            int dc  = (ld && sel == i) ? 1 : 0;
            n_cnt[i] = m_cnt[i] + inc - dc;
            if (n_cnt[i] > MAX) n_cnt[i] = MAX;
            if (inc == 1 && dc == 0 && m_cnt[i] == MAX) n_ovf[i] = 1'b1;
            else if (ovf_clr_i[i]) n_ovf[i] = 1'b0;
        end
        if (ld) begin
            n_valid = 1'b1;
            n_data  = 8'((int'(BASE) + sel) % 256);
            n_ptr   = sel;
        end else if (m_valid && event_ready_i) begin
            n_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
        m_cnt   = n_cnt;
        m_ovf   = n_ovf;
        m_ptr   = n_ptr;
        m_valid = n_valid;
        m_data  = n_data;
    endtask

    task automatic do_reset();
        enable_i      = 1'b1;
        src_evt_i     = '0;
        event_ready_i = 1'b1;
        ovf_clr_i     = '0;
        rstn_i        = 1'b0;
        #3;
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (event_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", event_valid_o); end
        total++; if (event_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", event_data_o); end
        total++; if (ovf_o !== '0) begin bad++; $display("FAIL reset_ovf got=%h want=00", ovf_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_single_pulse();
        do_reset();
        src_evt_i = 8'b0000_1000;
        tick();
        src_evt_i = '0;
        total++; if (event_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL single_t1 valid=%b busy=%b want valid=0 busy=1", event_valid_o, busy_o);
        end
        tick();
        total++; if (event_valid_o !== 1'b1 || event_data_o !== 8'h13) begin
            bad++; $display("FAIL single_t2 valid=%b data=%h want valid=1 data=13", event_valid_o, event_data_o);
        end
        tick();
        total++; if (event_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL single_t3 valid=%b busy=%b want 0 0", event_valid_o, busy_o);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] got [$];
        int first, last;
        do_reset();
        src_evt_i = 8'b0010_0101;
        tick();
        src_evt_i = '0;
        first = -1; last = -1;
        for (int c = 0; c < 8; c++) begin
            if (event_valid_o) begin
                got.push_back(event_data_o);
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        total++; if (got.size() != 3 || got[0] !== 8'h10 || got[1] !== 8'h12 || got[2] !== 8'h15) begin
            bad++; $display("FAIL rr_round1 got=%p want={10,12,15}", got);
        end
        total++; if (last - first != 2) begin
            bad++; $display("FAIL rr_back_to_back span=%0d want=2", last - first);
        end
        got.delete();
        src_evt_i = 8'b0010_0001;
        tick();
        src_evt_i = '0;
        for (int c = 0; c < 8; c++) begin
            if (event_valid_o) got.push_back(event_data_o);
            tick();
        end
        total++; if (got.size() != 2 || got[0] !== 8'h10 || got[1] !== 8'h15) begin
            bad++; $display("FAIL rr_round2 got=%p want={10,15}", got);
        end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        do_reset();
        event_ready_i = 1'b0;
        src_evt_i     = 8'b0100_0010;
        tick();
        src_evt_i = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            if (event_valid_o !== 1'b1 || event_data_o !== 8'h11) unstable++;
            tick();
        end
        total++; if (unstable != 0) begin
            bad++; $display("FAIL bp_hold unstable_cycles=%0d want=0", unstable);
        end
        event_ready_i = 1'b1;
        tick();
        event_ready_i = 1'b0;
        total++; if (event_valid_o !== 1'b1 || event_data_o !== 8'h16) begin
            bad++; $display("FAIL bp_next valid=%b data=%h want 1 16", event_valid_o, event_data_o);
        end
        tick();
        tick();
        total++; if (event_valid_o !== 1'b1 || event_data_o !== 8'h16) begin
            bad++; $display("FAIL bp_next_hold valid=%b data=%h want 1 16", event_valid_o, event_data_o);
        end
        event_ready_i = 1'b1;
        tick();
        total++; if (event_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL bp_drain valid=%b busy=%b want 0 0", event_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow();
        int n4 = 0;
        do_reset();
        enable_i  = 1'b0;
        src_evt_i = 8'b0001_0000;
        for (int c = 0; c < 5; c++) tick();
        src_evt_i = '0;
        total++; if (ovf_o !== 8'b0001_0000 || event_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL ovf_set ovf=%b valid=%b busy=%b want 00010000 0 1", ovf_o, event_valid_o, busy_o);
        end
        enable_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (event_valid_o && event_data_o == 8'h14) n4++;
            tick();
        end
        total++; if (n4 != 3) begin
            bad++; $display("FAIL ovf_drain events=%0d want=3", n4);
        end
        ovf_clr_i = 8'b0001_0000;
        tick();
        ovf_clr_i = '0;
        total++; if (ovf_o[4] !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=%b want=0", ovf_o[4]);
        end
        enable_i  = 1'b0;
        src_evt_i = 8'b0001_0000;
        for (int c = 0; c < 4; c++) tick();
        ovf_clr_i = 8'b0001_0000;
        tick();
        src_evt_i = '0;
        total++; if (ovf_o[4] !== 1'b1) begin
            bad++; $display("FAIL ovf_set_wins got=%b want=1", ovf_o[4]);
        end
        tick();
        ovf_clr_i = '0;
        total++; if (ovf_o[4] !== 1'b0) begin
            bad++; $display("FAIL ovf_clear2 got=%b want=0", ovf_o[4]);
        end
    endtask

    task automatic test_inc_dec();
        int gaps = 0;
        do_reset();
        src_evt_i = 8'b0000_0100;
        tick();
        tick();
        for (int c = 0; c < 20; c++) begin
            if (event_valid_o !== 1'b1 || event_data_o !== 8'h12 || ovf_o[2] !== 1'b0) gaps++;
            tick();
        end
        total++; if (gaps != 0) begin
            bad++; $display("FAIL incdec_stream bad_cycles=%0d want=0", gaps);
        end
        src_evt_i = '0;
        tick();
        total++; if (event_valid_o !== 1'b1) begin
            bad++; $display("FAIL incdec_last valid=%b want=1", event_valid_o);
        end
        tick();
        total++; if (event_valid_o !== 1'b0 || busy_o !== 1'b0 || ovf_o !== '0) begin
            bad++; $display("FAIL incdec_end valid=%b busy=%b ovf=%h want 0 0 00", event_valid_o, busy_o, ovf_o);
        end
    endtask

    task automatic test_reset_mid_offer();
        logic [7:0] got [$];
        do_reset();
        enable_i  = 1'b0;
        src_evt_i = 8'b0000_1000;
        for (int c = 0; c < 4; c++) tick();
        enable_i      = 1'b1;
        event_ready_i = 1'b0;
        src_evt_i     = 8'b0000_0110;
        tick();
        src_evt_i = '0;
        tick();
        total++; if (event_valid_o !== 1'b1 || busy_o !== 1'b1 || ovf_o[3] !== 1'b1) begin
            bad++; $display("FAIL rst_pre valid=%b busy=%b ovf3=%b want 1 1 1", event_valid_o, busy_o, ovf_o[3]);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        total++; if (event_valid_o !== 1'b0 || event_data_o !== 8'h00 || ovf_o !== '0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL rst_async valid=%b data=%h ovf=%h busy=%b want all 0",
                            event_valid_o, event_data_o, ovf_o, busy_o);
        end
        model_reset();
        @(negedge clk_i);
        rstn_i        = 1'b1;
        event_ready_i = 1'b1;
        src_evt_i     = 8'b1000_0001;
        tick();
        src_evt_i = '0;
        for (int c = 0; c < 8; c++) begin
            if (event_valid_o) got.push_back(event_data_o);
            tick();
        end
        total++; if (got.size() != 2 || got[0] !== 8'h10 || got[1] !== 8'h17) begin
            bad++; $display("FAIL rst_after got=%p want={10,17}", got);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                src_evt_i[i] = ($urandom_range(0, 99) < 18);
                ovf_clr_i[i] = ($urandom_range(0, 99) < 5);
            end
            event_ready_i = ($urandom_range(0, 3) != 0);
            enable_i      = ($urandom_range(0, 7) != 0);
            total++;
            if (event_valid_o !== m_valid || event_data_o !== m_data ||
                ovf_o !== m_ovf || busy_o !== m_busy()) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random cyc=%0d valid=%b/%b data=%h/%h ovf=%h/%h busy=%b/%b (got/want)",
                             c, event_valid_o, m_valid, event_data_o, m_data, ovf_o, m_ovf,
                             busy_o, m_busy());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_inc_dec();
        test_reset_mid_offer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
